// File: rtl/msgpack_tx_arbiter.sv
// Round-robin arbiter feeding one MessagePack scalar encoder (nil/bool/uint/sint).
// One item is granted per IDLE visit. It is then emitted as a header byte plus 0-8 big-endian payload bytes.
module msgpack_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [2*N_REQ-1:0]         req_kind,
  input  logic [64*N_REQ-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  typedef struct packed {
    logic [7:0] hdr;
    logic [3:0] len;
  } enc_t;

  // Header byte and payload length for one scalar.
  function automatic enc_t encode(input logic [1:0] kind, input logic [63:0] v);
    enc_t e;
    e.hdr = 8'hC0;
    e.len = 4'd0;
    case (kind)
      2'd0: e.hdr = 8'hC0;
      2'd1: e.hdr = {7'b1100001, v[0]};
      default: begin
        if (kind == 2'd3 && v[63]) begin
          if      (&v[63:5])  e.hdr = v[7:0];
          else if (&v[63:7])  begin e.hdr = 8'hD0; e.len = 4'd1; end
          else if (&v[63:15]) begin e.hdr = 8'hD1; e.len = 4'd2; end
          else if (&v[63:31]) begin e.hdr = 8'hD2; e.len = 4'd4; end
          else                begin e.hdr = 8'hD3; e.len = 4'd8; end
        end else begin
          if      (~|v[63:7])  e.hdr = v[7:0];
          else if (~|v[63:8])  begin e.hdr = 8'hCC; e.len = 4'd1; end
          else if (~|v[63:16]) begin e.hdr = 8'hCD; e.len = 4'd2; end
          else if (~|v[63:32]) begin e.hdr = 8'hCE; e.len = 4'd4; end
          else                 begin e.hdr = 8'hCF; e.len = 4'd8; end
        end
      end
    endcase
    return e;
  endfunction

  function automatic logic [7:0] byte_at(input logic [63:0] v, input logic [2:0] idx);
    return v[{idx, 3'b000} +: 8];
  endfunction

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [63:0]       payload_q, payload_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic [1:0]        win_kind;
  logic [63:0]       win_data;
  enc_t              win_enc;

  // Search starts at rr_ptr and wraps, so the first valid hit is the fair winner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign win_kind = req_kind[int'(winner)*2 +: 2];
  assign win_data = req_data[int'(winner)*64 +: 64];
  assign win_enc  = encode(win_kind, win_data);

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && found) req_ready[winner] = 1'b1;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    payload_d   = payload_q;
    grant_id_d  = grant_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = HDR;
          rr_ptr_d    = (int'(winner) == N_REQ-1) ? '0 : winner + ID_W'(1);
          cnt_d       = win_enc.len;
          payload_d   = win_data;
          grant_id_d  = winner;
          out_valid_d = 1'b1;
          out_data_d  = win_enc.hdr;
          out_last_d  = (win_enc.len == 4'd0);
        end
      end
      HDR: begin
        if (out_ready) begin
          if (cnt_q != 4'd0) begin
            state_d    = PAY;
            out_data_d = byte_at(payload_q, 3'(cnt_q - 4'd1));
            out_last_d = (cnt_q == 4'd1);
          end else begin
            state_d     = IDLE;
            grant_id_d  = '0;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_last_d  = 1'b0;
          end
        end
      end
      PAY: begin
        if (out_ready) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d     = IDLE;
            grant_id_d  = '0;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_last_d  = 1'b0;
          end else begin
            out_data_d = byte_at(payload_q, 3'(cnt_q - 4'd2));
            out_last_d = (cnt_q == 4'd2);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= 4'd0;
      payload_q   <= 64'd0;
      grant_id_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      payload_q   <= payload_d;
      grant_id_q  <= grant_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_msgpack_tx_arbiter.sv
// Scoreboard bench for msgpack_tx_arbiter: stimulus pushes expected bytes and a negedge monitor pops them.
module tb_msgpack_tx_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid;
  logic [2*N-1:0]   req_kind;
  logic [64*N-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic             busy;
  logic [1:0]       grant_id;

  msgpack_tx_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_kind(req_kind), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] gid;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_byte: got %0h expected no byte", out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_last", 64'(out_last), 64'(e.last));
        check("grant_id", 64'(grant_id), 64'(e.gid));
      end
    end
  end

  // bytes are right-aligned: the first byte of an n-byte item sits at [(n-1)*8 +: 8].
  task automatic push_item(input int gid, input int n, input logic [71:0] bytes);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = bytes[(n-1-i)*8 +: 8];
      e.last = (i == n-1);
      e.gid  = 2'(gid);
      q.push_back(e);
    end
  endtask

  task automatic wait_grant(input int idx);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got no req_ready expected req %0d", idx);
    end
    check("req_ready_onehot", 64'(req_ready), 64'(1) << idx);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_queue_le(input int lim);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      #1;
      if (q.size() <= lim) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL progress_timeout: got %0d bytes pending expected <= %0d", q.size(), lim);
    end
  endtask

  task automatic send_item(input int idx, input logic [1:0] kind, input logic [63:0] data,
                           input int n, input logic [71:0] bytes);
    push_item(idx, n, bytes);
    req_kind[idx*2 +: 2]  = kind;
    req_data[idx*64 +: 64] = data;
    req_valid[idx]        = 1'b1;
    wait_grant(idx);
    @(posedge clk);
    #1;
    req_valid[idx]         = 1'b0;
    req_data[idx*64 +: 64] = ~data;
    req_kind[idx*2 +: 2]   = kind ^ 2'd1;
    @(negedge clk);
    check("req_ready_single_pulse", 64'(req_ready), 64'd0);
    check("first_byte_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    req_valid = 4'b0101;
    req_kind  = '0;
    req_data  = '0;
    out_ready = 1'b1;

    // Reset values, with requests pending while rst is high.
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_grant_id",  64'(grant_id),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;

    // Single fixint item.
    send_item(0, 2'd2, 64'd5, 1, 72'h05);
    wait_idle();

    // Fairness from rr_ptr=0 after a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_kind  = '0;
    req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      wait_grant(g % 4);
      push_item(g % 4, 1, 72'hC0);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    wait_idle();

    // Width selection.
    send_item(1, 2'd2, 64'h1234, 3, 72'hCD1234);
    wait_idle();
    send_item(0, 2'd2, 64'h1_0000_0000, 9, 72'hCF0000000100000000);
    wait_idle();
    send_item(2, 2'd2, 64'd200, 2, 72'hCCC8);
    wait_idle();
    send_item(3, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 72'hFF);
    wait_idle();
    send_item(2, 2'd3, 64'hFFFF_FFFF_FFFF_FFDF, 2, 72'hD0DF);
    wait_idle();
    send_item(1, 2'd3, 64'hFFFF_FFFF_FFFF_FF38, 3, 72'hD1FF38);
    wait_idle();
    send_item(0, 2'd3, 64'd100, 1, 72'h64);
    wait_idle();
    send_item(3, 2'd2, 64'h8000_0000, 5, 72'hCE80000000);
    wait_idle();

    // Bool true then false from one requester, with one idle bubble between.
    push_item(2, 1, 72'hC3);
    push_item(2, 1, 72'hC2);
    req_kind[5:4]     = 2'd1;
    req_data[191:128] = 64'd1;
    req_valid[2]      = 1'b1;
    wait_grant(2);
    @(posedge clk);
    #1;
    req_data[191:128] = 64'd0;
    @(negedge clk);
    check("bool_hdr_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("bubble_out_valid", 64'(out_valid), 64'd0);
    check("bubble_req_ready", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wait_idle();

    // Backpressure while byte 0x01 of a CF item is presented.
    send_item(2, 2'd2, 64'h1_0000_0000, 9, 72'hCF0000000100000000);
    wait_queue_le(5);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_out_data",  64'(out_data),  64'h01);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_last",  64'(out_last),  64'd0);
      check("stall_grant_id",  64'(grant_id),  64'd2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Reset mid-payload, then req0 must win over req3.
    send_item(1, 2'd2, 64'h1_0000_0000, 9, 72'hCF0000000100000000);
    wait_queue_le(6);
    @(posedge clk);
    #1;
    out_ready         = 1'b0;
    rst               = 1'b1;
    req_kind[1:0]     = 2'd2;
    req_kind[7:6]     = 2'd2;
    req_data[63:0]    = 64'd5;
    req_data[255:192] = 64'd7;
    req_valid         = 4'b1001;
    @(negedge clk);
    check("rst_high_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    push_item(0, 1, 72'h05);
    push_item(3, 1, 72'h07);
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_busy",      64'(busy),      64'd0);
    check("post_rst_req_ready", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    out_ready    = 1'b1;
    wait_grant(3);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
